// File: rtl/timer_display_scan.sv
// Drives the 4-digit active-low multiplexed display from the countdown timer: BCD split, idle/run/expired phase, anode scan.
// Optional low-time and expiry blinking is compiled in when TIMER_DISP_BLINK_EN is defined.
module timer_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000,
  parameter int HOLD_CYCLES = 300000000,
  parameter int LOW_THRESH  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] time_display,
  input  logic       pause,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0] DASH  = 4'd10;
  localparam logic [3:0] BLANK = 4'd15;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [4:0]      val_q, ones_w;
  logic            pause_q;
  logic [1:0]      idx;
  logic [RW-1:0]   ref_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      tens, ones, code;
  logic            hold_done, blank;

  assign dp        = 1'b1;
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));

  always_comb begin
    tens   = 4'd0;
    ones_w = val_q;
    if (val_q >= 5'd30) begin
      tens = 4'd3; ones_w = val_q - 5'd30;
    end else if (val_q >= 5'd20) begin
      tens = 4'd2; ones_w = val_q - 5'd20;
    end else if (val_q >= 5'd10) begin
      tens = 4'd1; ones_w = val_q - 5'd10;
    end
    ones = ones_w[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the code shown on the currently scanned digit.
  always_comb begin
    state_nxt = state;
    code      = BLANK;
    case (state)
      IDLE: begin
        if (!pause_q) state_nxt = RUN;
        case (idx)
          2'd0:    code = ones;
          2'd1:    code = tens;
          default: code = DASH;
        endcase
      end
      RUN: begin
        if (pause_q) state_nxt = (val_q == 5'd0) ? EXPIRED : IDLE;
        if (idx == 2'd0) code = ones;
        else if (idx == 2'd1 && tens != 4'd0) code = tens;
      end
      EXPIRED: begin
        if (!pause_q) state_nxt = RUN;
        else if (hold_done) state_nxt = IDLE;
        if (idx <= 2'd1) code = 4'd0;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TIMER_DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [4:0] LOW_T = 5'(LOW_THRESH);

  logic [BW-1:0] blink_cnt;
  logic          phase, low_q, low_now, restart, phase_eff;

  assign low_now   = (val_q != 5'd0) && (val_q <= LOW_T);
  assign restart   = (state_nxt != state) || (state == RUN && low_now && !low_q);
  // A restarting cycle already counts as visible so a fresh warning never opens dark.
  assign phase_eff = restart ? 1'b1 : phase;
  assign blank     = !phase_eff && ((state == RUN && low_now) || state == EXPIRED);

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      low_q     <= 1'b0;
    end else begin
      low_q <= low_now;
      if (restart) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      DASH:    seg_of = 7'b0111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q    <= '0;
      pause_q  <= 1'b1;
      idx      <= '0;
      ref_cnt  <= '0;
      hold_cnt <= '0;
      seg      <= 7'h7F;
      an       <= 4'hF;
    end else begin
      val_q   <= time_display;
      pause_q <= pause;
      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      // Held at zero outside EXPIRED, so it always starts from zero on entry.
      hold_cnt <= (state == EXPIRED) ? hold_cnt + 1'b1 : '0;
      an       <= ~(4'b0001 << idx);
      seg      <= blank ? 7'h7F : seg_of(code);
    end
  end
endmodule

// File: tb/tb_timer_display_scan.sv
// Bench for timer_display_scan: a time-indexed display model predicts seg/an for every checked cycle.
module tb_timer_display_scan;
  localparam int REF = 4, BLK = 16, HOLD = 64, LOW = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2;
`ifdef TIMER_DISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] time_display = 5'd0;
  logic       pause = 1'b1;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n = 0, checks = 0, errors = 0;
  int m_state = M_IDLE, m_val = 0, origin = 0;
  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  timer_display_scan #(.REFRESH_DIV(REF), .BLINK_DIV(BLK), .HOLD_CYCLES(HOLD), .LOW_THRESH(LOW)) dut (
    .clk(clk), .reset(reset), .time_display(time_display), .pause(pause),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // n = number of active edges since reset was released.
  always @(posedge clk) n <= reset ? 0 : n + 1;

  function automatic bit is_low(input int v);
    return (v >= 1) && (v <= LOW);
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a = 4'b1111;
    a[((n - 1) / REF) % 4] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg();
    int d = ((n - 1) / REF) % 4;
    int t = m_val / 10;
    int o = m_val % 10;
    int e = n - origin - 1;
    bit vis = (e < 0) || (((e / BLK) % 2) == 0);
    logic [6:0] s = 7'h7F;
    if (m_state == M_IDLE) s = (d >= 2) ? 7'b0111111 : segtab[(d == 1) ? t : o];
    else if (m_state == M_RUN) begin
      if (d == 0) s = segtab[o];
      else if (d == 1 && t != 0) s = segtab[t];
    end else if (d <= 1) s = segtab[0];
    if (BLINK_EN && !vis && ((m_state == M_RUN && is_low(m_val)) || m_state == M_EXP)) s = 7'h7F;
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1; pause = 1'b1; time_display = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1)
      begin errors++; $display("FAIL reset_hold seg=%b an=%b dp=%b want 1111111/1111/1", seg, an, dp); end
    reset = 1'b0; m_state = M_IDLE; m_val = 0; origin = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg() || an !== exp_an() || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_scan n=%0d seg=%b an=%b dp=%b want %b %b 1", n, seg, an, dp, exp_seg(), exp_an());
      end
    end
  endtask

  task automatic test_idle();
    time_display = 5'd30; pause = 1'b1;
    repeat (2) @(negedge clk);
    m_val = 30;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg() || an !== exp_an())
        begin errors++; $display("FAIL idle n=%0d seg=%b an=%b want %b %b", n, seg, an, exp_seg(), exp_an()); end
    end
  endtask

  task automatic test_run();
    int vals [8];
    vals[0] = 7; vals[1] = 23;
    for (int k = 2; k < 8; k++) vals[k] = int'($urandom_range(31, 0));
    for (int k = 0; k < 8; k++) begin
      int n0 = n;
      time_display = 5'(vals[k]); pause = 1'b0;
      repeat (2) @(negedge clk);
      if (m_state != M_RUN || (is_low(vals[k]) && !is_low(m_val))) origin = n0 + 2;
      m_state = M_RUN; m_val = vals[k];
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        checks++;
        if (seg !== exp_seg() || an !== exp_an())
          begin errors++; $display("FAIL run v=%0d n=%0d seg=%b an=%b want %b %b", m_val, n, seg, an, exp_seg(), exp_an()); end
      end
    end
  endtask

  task automatic test_low_time();
    int vals [3] = '{6, 5, 0};
    int lens [3] = '{20, 70, 40};
    for (int k = 0; k < 3; k++) begin
      int n0 = n;
      time_display = 5'(vals[k]); pause = (vals[k] == 0);
      repeat (2) @(negedge clk);
      if ((is_low(vals[k]) && !is_low(m_val)) || vals[k] == 0) origin = n0 + 2;
      m_state = (vals[k] == 0) ? M_EXP : M_RUN; m_val = vals[k];
      for (int i = 0; i < lens[k]; i++) begin
        @(negedge clk);
        checks++;
        if (seg !== exp_seg() || an !== exp_an())
          begin errors++; $display("FAIL low_time v=%0d n=%0d seg=%b an=%b want %b %b", m_val, n, seg, an, exp_seg(), exp_an()); end
      end
    end
  endtask

  // Enter EXPIRED from RUN; abort_at < 0 waits out the hold, otherwise restart the game that many cycles in.
  task automatic test_expiry(input int abort_at);
    int n0 = n;
    time_display = 5'd12; pause = 1'b0;
    repeat (2) @(negedge clk);
    if (m_state != M_RUN) origin = n0 + 2;
    m_state = M_RUN; m_val = 12;
    repeat (10) @(negedge clk);
    n0 = n;
    time_display = 5'd0; pause = 1'b1;
    repeat (2) @(negedge clk);
    time_display = 5'd30;
    m_state = M_EXP; m_val = 0; origin = n0 + 2;
    for (int i = 0; i < ((abort_at < 0) ? HOLD : abort_at); i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg() || an !== exp_an())
        begin errors++; $display("FAIL expired_hold n=%0d seg=%b an=%b want %b %b", n, seg, an, exp_seg(), exp_an()); end
    end
    if (abort_at >= 0) begin
      n0 = n;
      pause = 1'b0;
      repeat (2) @(negedge clk);
      m_state = M_RUN; origin = n0 + 2;
    end else begin
      m_state = M_IDLE;
    end
    m_val = 30;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg() || an !== exp_an())
        begin errors++; $display("FAIL expired_exit st=%0d n=%0d seg=%b an=%b want %b %b", m_state, n, seg, an, exp_seg(), exp_an()); end
    end
  endtask

  task automatic test_reset_mid_run();
    int n0 = n;
    time_display = 5'd3; pause = 1'b0;
    repeat (2) @(negedge clk);
    if (!is_low(m_val)) origin = n0 + 2;
    m_val = 3;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1)
      begin errors++; $display("FAIL mid_reset seg=%b an=%b dp=%b want 1111111/1111/1", seg, an, dp); end
    reset = 1'b0;
    m_state = M_IDLE; m_val = 0;
    @(negedge clk);
    checks++;
    if (seg !== exp_seg() || an !== exp_an())
      begin errors++; $display("FAIL post_reset_first seg=%b an=%b want %b %b", seg, an, exp_seg(), exp_an()); end
    @(negedge clk);
    m_state = M_RUN; m_val = 3; origin = 2;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg() || an !== exp_an())
        begin errors++; $display("FAIL post_reset_run n=%0d seg=%b an=%b want %b %b", n, seg, an, exp_seg(), exp_an()); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_run();
    test_low_time();
    test_expiry(-1);
    test_expiry(18);
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
